// File: rtl/mc_sequencer_if.sv
// Datapath-facing signal bundle for mc_sequencer; the sequencer uses the master modport.
// Breakpoint inputs bp_en/bp_addr exist only when SEQ_BREAKPOINT_EN is defined.
interface mc_sequencer_if #(
  parameter int PC_W = 5
) ();
  logic            run;
  logic            step;
  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic            is_branch;
  logic [PC_W-1:0] branch_target;
`ifdef SEQ_BREAKPOINT_EN
  logic            bp_en;
  logic [PC_W-1:0] bp_addr;
`endif
  logic [PC_W-1:0] pc;
  logic            ir_we;
  logic            rf_we;
  logic            dm_re;
  logic            dm_we;
  logic            io_in;
  logic            io_out;
  logic            pc_we;
  logic [2:0]      state;
  logic            halted;
  logic [7:0]      instr_count;

`ifdef SEQ_BREAKPOINT_EN
  modport master (
    input  run, step, opcode, funct, is_branch, branch_target, bp_en, bp_addr,
    output pc, ir_we, rf_we, dm_re, dm_we, io_in, io_out, pc_we, state, halted, instr_count
  );
  modport slave (
    output run, step, opcode, funct, is_branch, branch_target, bp_en, bp_addr,
    input  pc, ir_we, rf_we, dm_re, dm_we, io_in, io_out, pc_we, state, halted, instr_count
  );
`else
  modport master (
    input  run, step, opcode, funct, is_branch, branch_target,
    output pc, ir_we, rf_we, dm_re, dm_we, io_in, io_out, pc_we, state, halted, instr_count
  );
  modport slave (
    output run, step, opcode, funct, is_branch, branch_target,
    input  pc, ir_we, rf_we, dm_re, dm_we, io_in, io_out, pc_we, state, halted, instr_count
  );
`endif
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer owning the PC and retired count.
// Optional PC breakpoint support is compiled in with SEQ_BREAKPOINT_EN.
module mc_sequencer #(
  parameter int PC_W      = 5,
  parameter int PROG_LEN  = 31,
  parameter int MAX_INSTR = 31
) (
  input logic            clk,
  input logic            reset,
  mc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_IN    = 6'b100000;
  localparam logic [5:0] OP_OUT   = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [7:0] MAX_CNT  = 8'(MAX_INSTR);

  state_t          r_state;
  state_t          w_next_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_next_pc;
  logic [7:0]      r_count;
  logic [7:0]      w_count_inc;
  logic            r_step_q;
  logic            w_step_edge;
  logic            w_is_mem;
  logic            w_writes_rf;
  logic            w_prog_end;
  logic            w_budget_end;
  logic            w_start;
  logic            w_bp_hit;
  logic            w_ir_we, w_rf_we, w_dm_re, w_dm_we, w_io_in, w_io_out, w_pc_we;

  assign w_step_edge  = bus.step & ~r_step_q;
  assign w_is_mem     = (bus.opcode == OP_LW) || (bus.opcode == OP_SW) ||
                        (bus.opcode == OP_IN) || (bus.opcode == OP_OUT);
  assign w_writes_rf  = !((bus.opcode == OP_SW)  || (bus.opcode == OP_OUT) ||
                          (bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE) ||
                          (bus.opcode == OP_J)   ||
                          ((bus.opcode == OP_RTYPE) && (bus.funct == FN_JR)));
  assign w_next_pc    = bus.is_branch ? bus.branch_target : r_pc + 1'b1;
  assign w_count_inc  = (r_count == 8'hFF) ? 8'hFF : r_count + 8'd1;
  assign w_prog_end   = {{(32-PC_W){1'b0}}, w_next_pc} >= 32'(PROG_LEN);
  assign w_budget_end = (w_count_inc == MAX_CNT);

`ifdef SEQ_BREAKPOINT_EN
  logic r_run_q;
  logic r_bp_hold;  // parked at a breakpoint: needs a step edge or a fresh run rise
  logic r_bp_skip;  // instruction resumed from a breakpoint may not re-break

  assign w_start  = r_bp_hold ? (w_step_edge | (bus.run & ~r_run_q))
                              : (bus.run | w_step_edge);
  assign w_bp_hit = bus.run & bus.bp_en & (w_next_pc == bus.bp_addr) & ~r_bp_skip;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_run_q   <= 1'b0;
      r_bp_hold <= 1'b0;
      r_bp_skip <= 1'b0;
    end else begin
      r_run_q <= bus.run;
      if (r_state == S_IDLE && w_start) begin
        r_bp_skip <= r_bp_hold;
        r_bp_hold <= 1'b0;
      end else if (r_state == S_WB) begin
        r_bp_skip <= 1'b0;
        if (!w_prog_end && !w_budget_end && w_bp_hit) r_bp_hold <= 1'b1;
      end
    end
  end
`else
  assign w_start  = bus.run | w_step_edge;
  assign w_bp_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_count  <= '0;
      r_step_q <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_step_q <= bus.step;
      if (r_state == S_WB) begin
        r_pc    <= w_next_pc;
        r_count <= w_count_inc;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:   if (w_start) w_next_state = S_FETCH;
      S_FETCH:  w_next_state = S_DECODE;
      S_DECODE: w_next_state = S_EXEC;
      S_EXEC:   w_next_state = w_is_mem ? S_MEM : S_WB;
      S_MEM:    w_next_state = S_WB;
      S_WB: begin
        if (w_prog_end || w_budget_end)  w_next_state = S_HALT;
        else if (bus.run && !w_bp_hit)   w_next_state = S_FETCH;
        else                             w_next_state = S_IDLE;
      end
      S_HALT:   w_next_state = S_HALT;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Strobes follow the state register so each write fires once per instruction.
  always_comb begin
    w_ir_we  = 1'b0;
    w_rf_we  = 1'b0;
    w_dm_re  = 1'b0;
    w_dm_we  = 1'b0;
    w_io_in  = 1'b0;
    w_io_out = 1'b0;
    w_pc_we  = 1'b0;
    case (r_state)
      S_FETCH: w_ir_we = 1'b1;
      S_MEM: begin
        w_dm_re  = (bus.opcode == OP_LW);
        w_dm_we  = (bus.opcode == OP_SW);
        w_io_in  = (bus.opcode == OP_IN);
        w_io_out = (bus.opcode == OP_OUT);
      end
      S_WB: begin
        w_pc_we = 1'b1;
        w_rf_we = w_writes_rf;
      end
      default: ;
    endcase
  end

  assign bus.pc          = r_pc;
  assign bus.ir_we       = w_ir_we;
  assign bus.rf_we       = w_rf_we;
  assign bus.dm_re       = w_dm_re;
  assign bus.dm_we       = w_dm_we;
  assign bus.io_in       = w_io_in;
  assign bus.io_out      = w_io_out;
  assign bus.pc_we       = w_pc_we;
  assign bus.state       = r_state;
  assign bus.halted      = (r_state == S_HALT);
  assign bus.instr_count = r_count;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: default instance plus MAX_INSTR=3 and PROG_LEN=2 instances.
module tb_mc_sequencer;

  localparam logic [6:0] IR  = 7'b1000000;
  localparam logic [6:0] RF  = 7'b0100000;
  localparam logic [6:0] DRE = 7'b0010000;
  localparam logic [6:0] DWE = 7'b0001000;
  localparam logic [6:0] IIN = 7'b0000100;
  localparam logic [6:0] IOU = 7'b0000010;
  localparam logic [6:0] PCW = 7'b0000001;
  localparam logic [5:0] ADDI = 6'b001000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  mc_sequencer_if #(.PC_W(5)) b0 ();
  mc_sequencer_if #(.PC_W(5)) b1 ();
  mc_sequencer_if #(.PC_W(5)) b2 ();

  mc_sequencer #(.PC_W(5), .PROG_LEN(31), .MAX_INSTR(31)) u0 (.clk(clk), .reset(reset), .bus(b0));
  mc_sequencer #(.PC_W(5), .PROG_LEN(31), .MAX_INSTR(3))  u1 (.clk(clk), .reset(reset), .bus(b1));
  mc_sequencer #(.PC_W(5), .PROG_LEN(2),  .MAX_INSTR(31)) u2 (.clk(clk), .reset(reset), .bus(b2));

  function automatic logic [6:0] strb0();
    return {b0.ir_we, b0.rf_we, b0.dm_re, b0.dm_we, b0.io_in, b0.io_out, b0.pc_we};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tests_run++;
    if (b0.state !== 3'd0) begin tests_failed++; $display("FAIL reset_state: got %0d want 0", b0.state); end
    tests_run++;
    if (b0.pc !== 5'd0 || b0.instr_count !== 8'd0) begin
      tests_failed++; $display("FAIL reset_pc_count: got pc=%0d cnt=%0d want 0/0", b0.pc, b0.instr_count);
    end
    tests_run++;
    if (strb0() !== 7'd0 || b0.halted !== 1'b0) begin
      tests_failed++; $display("FAIL reset_strobes: got %b halted=%b want 0", strb0(), b0.halted);
    end
    tick(); tick();
    tests_run++;
    if (b0.state !== 3'd0) begin tests_failed++; $display("FAIL idle_hold: got %0d want 0", b0.state); end
  endtask

  // One addi from IDLE; run drops during DECODE so the sequencer parks in IDLE.
  task automatic test_addi();
    logic [2:0] exp_s [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
    logic [6:0] exp_b [4] = '{IR, 7'd0, 7'd0, RF | PCW};
    b0.opcode = ADDI; b0.funct = 6'd0; b0.is_branch = 1'b0; b0.branch_target = 5'd0;
    b0.run = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 1) b0.run = 1'b0;
      tests_run++;
      if (b0.state !== exp_s[i] || strb0() !== exp_b[i]) begin
        tests_failed++;
        $display("FAIL addi_cycle%0d: got state=%0d strb=%b want state=%0d strb=%b", i, b0.state, strb0(), exp_s[i], exp_b[i]);
      end
    end
    tick();
    tests_run++;
    if (b0.state !== 3'd0 || b0.pc !== 5'd1 || b0.instr_count !== 8'd1) begin
      tests_failed++; $display("FAIL addi_retire: got state=%0d pc=%0d cnt=%0d want 0/1/1", b0.state, b0.pc, b0.instr_count);
    end
  endtask

  // lw, sw, in, out back to back in run mode; run drops during the last FETCH.
  task automatic test_memory();
    logic [5:0] ops [4] = '{6'b100011, 6'b101011, 6'b100000, 6'b100001};
    logic [6:0] mem [4] = '{DRE, DWE, IIN, IOU};
    logic [6:0] wb  [4] = '{RF | PCW, PCW, RF | PCW, PCW};
    b0.opcode = ops[0]; b0.is_branch = 1'b0; b0.run = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      b0.opcode = ops[i];
      if (i == 3) b0.run = 1'b0;
      tests_run++;
      if (b0.state !== 3'd1 || strb0() !== IR || b0.pc !== 5'(1 + i)) begin
        tests_failed++; $display("FAIL mem%0d_fetch: got state=%0d strb=%b pc=%0d want 1/%b/%0d", i, b0.state, strb0(), b0.pc, IR, 1 + i);
      end
      tick(); tick();
      tests_run++;
      if (b0.state !== 3'd3 || strb0() !== 7'd0) begin
        tests_failed++; $display("FAIL mem%0d_exec: got state=%0d strb=%b want 3/0", i, b0.state, strb0());
      end
      tick();
      tests_run++;
      if (b0.state !== 3'd4 || strb0() !== mem[i]) begin
        tests_failed++; $display("FAIL mem%0d_mem: got state=%0d strb=%b want 4/%b", i, b0.state, strb0(), mem[i]);
      end
      tick();
      tests_run++;
      if (b0.state !== 3'd5 || strb0() !== wb[i]) begin
        tests_failed++; $display("FAIL mem%0d_wb: got state=%0d strb=%b want 5/%b", i, b0.state, strb0(), wb[i]);
      end
      tick();
    end
    tests_run++;
    if (b0.state !== 3'd0 || b0.pc !== 5'd5 || b0.instr_count !== 8'd5) begin
      tests_failed++; $display("FAIL mem_end: got state=%0d pc=%0d cnt=%0d want 0/5/5", b0.state, b0.pc, b0.instr_count);
    end
  endtask

  // bne taken, jal, jr, j, beq not taken: rf_we and pc redirect per instruction.
  task automatic test_branch();
    logic [5:0] ops [5] = '{6'b000101, 6'b000011, 6'b000000, 6'b000010, 6'b000100};
    logic [5:0] fns [5] = '{6'd0, 6'd0, 6'b001000, 6'd0, 6'd0};
    logic       brs [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0] tgt [5] = '{5'd21, 5'd7, 5'd10, 5'd12, 5'd30};
    logic [4:0] npc [5] = '{5'd21, 5'd7, 5'd10, 5'd12, 5'd13};
    logic [6:0] wb  [5] = '{PCW, RF | PCW, PCW, PCW, PCW};
    for (int i = 0; i < 5; i++) begin
      b0.opcode = ops[i]; b0.funct = fns[i]; b0.is_branch = brs[i]; b0.branch_target = tgt[i];
      b0.run = 1'b1;
      tick();
      b0.run = 1'b0;
      tick(); tick(); tick();
      tests_run++;
      if (b0.state !== 3'd5 || strb0() !== wb[i]) begin
        tests_failed++; $display("FAIL br%0d_wb: got state=%0d strb=%b want 5/%b", i, b0.state, strb0(), wb[i]);
      end
      tick();
      tests_run++;
      if (b0.state !== 3'd0 || b0.pc !== npc[i] || b0.instr_count !== 8'(6 + i)) begin
        tests_failed++; $display("FAIL br%0d_retire: got state=%0d pc=%0d cnt=%0d want 0/%0d/%0d", i, b0.state, b0.pc, b0.instr_count, npc[i], 6 + i);
      end
    end
    b0.funct = 6'd0; b0.is_branch = 1'b0;
  endtask

  // Held step runs a single instruction; a fresh rising edge runs exactly one more.
  task automatic test_step();
    b0.opcode = ADDI; b0.run = 1'b0;
    for (int k = 0; k < 2; k++) begin
      b0.step = 1'b1;
      for (int c = 0; c < 20; c++) tick();
      tests_run++;
      if (b0.state !== 3'd0 || b0.instr_count !== 8'(11 + k) || b0.pc !== 5'(14 + k)) begin
        tests_failed++; $display("FAIL step%0d: got state=%0d cnt=%0d pc=%0d want 0/%0d/%0d", k, b0.state, b0.instr_count, b0.pc, 11 + k, 14 + k);
      end
      b0.step = 1'b0;
      tick();
    end
  endtask

  // Jump to pc=30; the next instruction produces pc=31 = PROG_LEN and halts.
  task automatic test_prog_end();
    b0.opcode = 6'b000010; b0.is_branch = 1'b1; b0.branch_target = 5'd30; b0.run = 1'b1;
    tick();
    b0.run = 1'b0;
    tick(); tick(); tick(); tick();
    b0.opcode = ADDI; b0.is_branch = 1'b0; b0.run = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    tests_run++;
    if (b0.state !== 3'd6 || b0.halted !== 1'b1 || b0.pc !== 5'd31 || b0.instr_count !== 8'd14) begin
      tests_failed++; $display("FAIL prog_end_halt: got state=%0d halted=%b pc=%0d cnt=%0d want 6/1/31/14", b0.state, b0.halted, b0.pc, b0.instr_count);
    end
    for (int c = 0; c < 6; c++) begin
      b0.step = c[0];
      b0.run  = ~c[1];
      tick();
    end
    tests_run++;
    if (b0.state !== 3'd6 || b0.instr_count !== 8'd14 || strb0() !== 7'd0) begin
      tests_failed++; $display("FAIL halt_absorb: got state=%0d cnt=%0d strb=%b want 6/14/0", b0.state, b0.instr_count, strb0());
    end
    b0.step = 1'b0; b0.run = 1'b0;
  endtask

  // Reset asserted for two cycles while an lw sits in MEM.
  task automatic test_reset_mid_mem();
    reset = 1'b0; tick(); reset = 1'b1;
    b0.opcode = 6'b100011; b0.run = 1'b1;
    tick(); tick(); tick(); tick();
    tests_run++;
    if (b0.state !== 3'd4 || b0.dm_re !== 1'b1) begin
      tests_failed++; $display("FAIL pre_reset_mem: got state=%0d dm_re=%b want 4/1", b0.state, b0.dm_re);
    end
    reset = 1'b0; b0.run = 1'b0;
    tick(); tick();
    tests_run++;
    if (b0.state !== 3'd0 || b0.pc !== 5'd0 || b0.instr_count !== 8'd0 || strb0() !== 7'd0 || b0.halted !== 1'b0) begin
      tests_failed++; $display("FAIL reset_mid_mem: got state=%0d pc=%0d cnt=%0d strb=%b halted=%b want all 0", b0.state, b0.pc, b0.instr_count, strb0(), b0.halted);
    end
    reset = 1'b1;
    tick();
    tests_run++;
    if (b0.state !== 3'd0) begin tests_failed++; $display("FAIL post_reset_idle: got %0d want 0", b0.state); end
  endtask

  // MAX_INSTR=3 instance: halts after the third WB and ignores run/step until reset.
  task automatic test_max_instr();
    b1.opcode = ADDI; b1.run = 1'b1;
    for (int c = 0; c < 9; c++) tick();
    tests_run++;
    if (b1.state !== 3'd1 || b1.instr_count !== 8'd2 || b1.pc !== 5'd2) begin
      tests_failed++; $display("FAIL max_b2b: got state=%0d cnt=%0d pc=%0d want 1/2/2", b1.state, b1.instr_count, b1.pc);
    end
    for (int c = 0; c < 4; c++) tick();
    tests_run++;
    if (b1.state !== 3'd6 || b1.halted !== 1'b1 || b1.instr_count !== 8'd3 || b1.pc !== 5'd3) begin
      tests_failed++; $display("FAIL max_halt: got state=%0d halted=%b cnt=%0d pc=%0d want 6/1/3/3", b1.state, b1.halted, b1.instr_count, b1.pc);
    end
    for (int c = 0; c < 6; c++) begin
      b1.step = c[0];
      b1.run  = c[1];
      tick();
    end
    tests_run++;
    if (b1.state !== 3'd6 || b1.instr_count !== 8'd3) begin
      tests_failed++; $display("FAIL max_absorb: got state=%0d cnt=%0d want 6/3", b1.state, b1.instr_count);
    end
    b1.step = 1'b0; b1.run = 1'b0;
    reset = 1'b0; tick(); tick(); reset = 1'b1;
    tests_run++;
    if (b1.state !== 3'd0 || b1.halted !== 1'b0 || b1.instr_count !== 8'd0) begin
      tests_failed++; $display("FAIL max_reset: got state=%0d halted=%b cnt=%0d want 0/0/0", b1.state, b1.halted, b1.instr_count);
    end
  endtask

  // PROG_LEN=2 instance: the pc=1 instruction is the last one.
  task automatic test_prog_len();
    b2.opcode = ADDI; b2.run = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    tests_run++;
    if (b2.state !== 3'd1 || b2.pc !== 5'd1) begin
      tests_failed++; $display("FAIL plen_second: got state=%0d pc=%0d want 1/1", b2.state, b2.pc);
    end
    for (int c = 0; c < 4; c++) tick();
    tests_run++;
    if (b2.state !== 3'd6 || b2.halted !== 1'b1 || b2.pc !== 5'd2 || b2.instr_count !== 8'd2) begin
      tests_failed++; $display("FAIL plen_halt: got state=%0d halted=%b pc=%0d cnt=%0d want 6/1/2/2", b2.state, b2.halted, b2.pc, b2.instr_count);
    end
    b2.run = 1'b0;
  endtask

  initial begin
    b0.run = 1'b0; b0.step = 1'b0; b0.opcode = 6'd0; b0.funct = 6'd0; b0.is_branch = 1'b0; b0.branch_target = 5'd0;
    b1.run = 1'b0; b1.step = 1'b0; b1.opcode = 6'd0; b1.funct = 6'd0; b1.is_branch = 1'b0; b1.branch_target = 5'd0;
    b2.run = 1'b0; b2.step = 1'b0; b2.opcode = 6'd0; b2.funct = 6'd0; b2.is_branch = 1'b0; b2.branch_target = 5'd0;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    test_reset();
    test_addi();
    test_memory();
    test_branch();
    test_step();
    test_prog_end();
    test_reset_mid_mem();
    test_max_instr();
    test_prog_len();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
